// File: rtl/router_pkg.sv
// Shared constants and types for the 1x3 packet router.
// Header byte layout: [7:2] payload length, [1:0] destination channel address.
package router_pkg;

  // Data byte width used across the router datapath.
  localparam int unsigned DW = 8;

  // Header field positions.
  localparam int unsigned AddrLsb = 0;
  localparam int unsigned AddrMsb = 1;
  localparam int unsigned LenLsb  = 2;
  localparam int unsigned LenMsb  = 7;

  // Largest payload a header can announce.
  localparam int unsigned MaxPayload = 63;

  // Width of the per-channel packet byte counter.
  localparam int unsigned PktCntW = 6;

  // Destination channel encodings carried in the header address field.
  typedef enum logic [1:0] {
    ChAddr0 = 2'b00,
    ChAddr1 = 2'b01,
    ChAddr2 = 2'b10
  } ch_addr_e;

  // Bytes still to come after a header: payload plus one parity byte.
  // A length-63 header wraps the 6-bit count to zero.
  function automatic logic [PktCntW-1:0] hdr_remaining(input logic [DW-1:0] hdr);
    return PktCntW'(hdr[LenMsb:LenLsb]) + PktCntW'(1);
  endfunction

endpackage

// File: rtl/router_fifo_ptr.sv
// Read/write pointer pair with full/empty decode for a power-of-two FIFO.
// Pointers carry one extra wrap bit so full and empty can be told apart.
// Ports:
//   clock   rising-edge clock
//   clear   synchronous clear of both pointers (highest priority)
//   wr_inc  advance write pointer (caller guarantees !full)
//   rd_inc  advance read pointer (caller guarantees !empty)
//   wr_ptr  current write pointer, AW+1 bits
//   rd_ptr  current read pointer, AW+1 bits
//   full    no free entry
//   empty   no stored entry
module router_fifo_ptr #(
  parameter int unsigned AW = 4
) (
  input  logic        clock,
  input  logic        clear,
  input  logic        wr_inc,
  input  logic        rd_inc,
  output logic [AW:0] wr_ptr,
  output logic [AW:0] rd_ptr,
  output logic        full,
  output logic        empty
);

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_inc) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    if (rd_inc) rd_ptr_d = rd_ptr_q + (AW+1)'(1);
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  assign wr_ptr = wr_ptr_q;
  assign rd_ptr = rd_ptr_q;

  // Same slot, different lap: writer is exactly one lap ahead.
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty = (wr_ptr_q == rd_ptr_q);

endmodule

// File: rtl/router_fifo_ch.sv
// One output-channel FIFO of the 1x3 packet router.
// Stores {hdr_flag, byte} words and tracks packet boundaries on the read side so the
// output bus returns to zero once a packet has been fully drained.
// Ports:
//   clock       rising-edge clock
//   reset       synchronous active-high reset, highest priority
//   soft_reset  synchronous flush from the synchronizer timeout
//   write_enb   write strobe from the synchronizer
//   read_enb    read strobe from the destination
//   lfd_state   marks data_in as a header byte
//   data_in     byte from the router input register
//   data_out    registered read data, valid the edge after a read strobe
//   full        no free entry
//   empty       no stored entry
module router_fifo_ch #(
  parameter int unsigned DW    = router_pkg::DW,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          soft_reset,
  input  logic          write_enb,
  input  logic          read_enb,
  input  logic          lfd_state,
  input  logic [DW-1:0] data_in,
  output logic [DW-1:0] data_out,
  output logic          full,
  output logic          empty
);

  import router_pkg::*;

  logic              clear;
  logic              wr_fire;
  logic              rd_fire;
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic [DW:0]       rd_word;

  logic [DW:0]       mem_q [DEPTH];

  logic [DW-1:0]     data_out_q, data_out_d;
  logic [PktCntW-1:0] pkt_cnt_q, pkt_cnt_d;

  assign clear = reset || soft_reset;

  // full/empty come from the pre-edge pointers, so a write while full is dropped
  // even if a read frees a slot in the same cycle.
  assign wr_fire = write_enb && !full && !clear;
  assign rd_fire = read_enb && !empty && !clear;

  router_fifo_ptr #(
    .AW (AW)
  ) u_ptr (
    .clock  (clock),
    .clear  (clear),
    .wr_inc (wr_fire),
    .rd_inc (rd_fire),
    .wr_ptr (wr_ptr),
    .rd_ptr (rd_ptr),
    .full   (full),
    .empty  (empty)
  );

  // Storage is never cleared; a flush only moves the pointers.
  always_ff @(posedge clock) begin
    if (wr_fire) begin
      mem_q[wr_ptr[AW-1:0]] <= {lfd_state, data_in};
    end
  end

  assign rd_word = mem_q[rd_ptr[AW-1:0]];

  always_comb begin
    data_out_d = data_out_q;
    pkt_cnt_d  = pkt_cnt_q;
    if (rd_fire) begin
      data_out_d = rd_word[DW-1:0];
      if (rd_word[DW]) begin
        pkt_cnt_d = hdr_remaining(rd_word[DW-1:0]);
      end else if (pkt_cnt_q != '0) begin
        pkt_cnt_d = pkt_cnt_q - PktCntW'(1);
      end
    end else if (pkt_cnt_q == '0) begin
      // Packet finished and nothing read: idle the bus.
      data_out_d = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      data_out_q <= '0;
      pkt_cnt_q  <= '0;
    end else begin
      data_out_q <= data_out_d;
      pkt_cnt_q  <= pkt_cnt_d;
    end
  end

  assign data_out = data_out_q;

  full_empty_exclusive: assert property (@(posedge clock) disable iff (reset) !(full && empty));

endmodule

// File: tb/tb_router_fifo_ch.sv
module tb_router_fifo_ch;

  localparam int unsigned Depth = 16;

  logic       clock;
  logic       reset;
  logic       soft_reset;
  logic       write_enb;
  logic       read_enb;
  logic       lfd_state;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       full;
  logic       empty;

  int checks = 0;
  int errors = 0;

  router_fifo_ch dut (
    .clock      (clock),
    .reset      (reset),
    .soft_reset (soft_reset),
    .write_enb  (write_enb),
    .read_enb   (read_enb),
    .lfd_state  (lfd_state),
    .data_in    (data_in),
    .data_out   (data_out),
    .full       (full),
    .empty      (empty)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Reference model: a queue of {hdr_flag, byte} words plus the packet bookkeeping.
  logic [8:0] mq[$];
  logic [7:0] m_dout;
  logic [5:0] m_pkt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge(input logic rst, input logic srst, input logic we, input logic re,
                            input logic lfd, input logic [7:0] din);
    logic       do_rd;
    logic       do_wr;
    logic [8:0] w;
    if (rst || srst) begin
      mq.delete();
      m_dout = 8'h00;
      m_pkt  = 6'd0;
    end else begin
      do_rd = re && (mq.size() != 0);
      do_wr = we && (mq.size() != Depth);
      if (do_rd) begin
        w      = mq.pop_front();
        m_dout = w[7:0];
        if (w[8]) m_pkt = 6'(w[7:2] + 6'd1);
        else if (m_pkt != 0) m_pkt = m_pkt - 6'd1;
      end else if (m_pkt == 0) begin
        m_dout = 8'h00;
      end
      if (do_wr) mq.push_back({lfd, din});
    end
  endtask

  // One clock: drive, take the edge, update model, sample 1 ns later, compare to model.
  task automatic cyc(input logic rst, input logic srst, input logic we, input logic re,
                     input logic lfd, input logic [7:0] din);
    reset = rst; soft_reset = srst; write_enb = we; read_enb = re;
    lfd_state = lfd; data_in = din;
    @(posedge clock);
    model_edge(rst, srst, we, re, lfd, din);
    #1;
    check("model_dout", 32'(data_out), 32'(m_dout));
    check("model_full", 32'(full), 32'(mq.size() == Depth));
    check("model_empty", 32'(empty), 32'(mq.size() == 0));
  endtask

  typedef struct {
    logic       rst, srst, we, re, lfd;
    logic [7:0] din;
    logic [7:0] dout;
    logic       full, empty;
  } vec_t;

  vec_t vecs[$];

  initial begin
    reset = 1'b0; soft_reset = 1'b0; write_enb = 1'b0; read_enb = 1'b0;
    lfd_state = 1'b0; data_in = 8'h00;
    m_dout = 8'h00; m_pkt = 6'd0;

    // Reset, then one packet: header 0D (len 3, addr 01), 3 payload, parity.
    //                rst  srst we   re   lfd  din    dout   full empty
    vecs.push_back('{1'b1,1'b0,1'b0,1'b0,1'b0,8'h00, 8'h00, 1'b0,1'b1});
    vecs.push_back('{1'b0,1'b0,1'b1,1'b0,1'b1,8'h0D, 8'h00, 1'b0,1'b0});
    vecs.push_back('{1'b0,1'b0,1'b1,1'b0,1'b0,8'h11, 8'h00, 1'b0,1'b0});
    vecs.push_back('{1'b0,1'b0,1'b1,1'b0,1'b0,8'h22, 8'h00, 1'b0,1'b0});
    vecs.push_back('{1'b0,1'b0,1'b1,1'b0,1'b0,8'h33, 8'h00, 1'b0,1'b0});
    vecs.push_back('{1'b0,1'b0,1'b1,1'b0,1'b0,8'h5A, 8'h00, 1'b0,1'b0});
    vecs.push_back('{1'b0,1'b0,1'b0,1'b1,1'b0,8'h00, 8'h0D, 1'b0,1'b0});
    vecs.push_back('{1'b0,1'b0,1'b0,1'b1,1'b0,8'h00, 8'h11, 1'b0,1'b0});
    vecs.push_back('{1'b0,1'b0,1'b0,1'b1,1'b0,8'h00, 8'h22, 1'b0,1'b0});
    vecs.push_back('{1'b0,1'b0,1'b0,1'b1,1'b0,8'h00, 8'h33, 1'b0,1'b0});
    vecs.push_back('{1'b0,1'b0,1'b0,1'b1,1'b0,8'h00, 8'h5A, 1'b0,1'b1});
    vecs.push_back('{1'b0,1'b0,1'b0,1'b0,1'b0,8'h00, 8'h00, 1'b0,1'b1});

    for (int i = 0; i < vecs.size(); i++) begin
      cyc(vecs[i].rst, vecs[i].srst, vecs[i].we, vecs[i].re, vecs[i].lfd, vecs[i].din);
      check($sformatf("vec%0d_dout", i), 32'(data_out), 32'(vecs[i].dout));
      check($sformatf("vec%0d_full", i), 32'(full), 32'(vecs[i].full));
      check($sformatf("vec%0d_empty", i), 32'(empty), 32'(vecs[i].empty));
    end

    // Fill to 16, 17th write dropped, drain in order.
    cyc(1, 0, 0, 0, 0, 8'h00);
    for (int i = 0; i < 16; i++) cyc(0, 0, 1, 0, 0, 8'(i + 8'h40));
    check("fill16_full", 32'(full), 32'd1);
    cyc(0, 0, 1, 0, 0, 8'hFF);
    check("write17_full", 32'(full), 32'd1);
    for (int i = 0; i < 16; i++) begin
      cyc(0, 0, 0, 1, 0, 8'h00);
      check("drain_order", 32'(data_out), 32'(i + 8'h40));
    end
    check("drain_empty", 32'(empty), 32'd1);

    // Full FIFO: read and write together -> read wins, write dropped.
    cyc(1, 0, 0, 0, 0, 8'h00);
    for (int i = 0; i < 16; i++) cyc(0, 0, 1, 0, 0, 8'(i + 8'h80));
    cyc(0, 0, 1, 1, 0, 8'hEE);
    check("rw_full_dout", 32'(data_out), 32'h80);
    check("rw_full_notfull", 32'(full), 32'd0);
    for (int i = 1; i < 16; i++) begin
      cyc(0, 0, 0, 1, 0, 8'h00);
      check("rw_full_drain", 32'(data_out), 32'(i + 8'h80));
    end
    check("rw_full_occ15", 32'(empty), 32'd1);

    // Soft reset mid-packet, then a new packet reads correctly.
    cyc(1, 0, 0, 0, 0, 8'h00);
    cyc(0, 0, 1, 0, 1, 8'h28);
    for (int i = 1; i < 10; i++) cyc(0, 0, 1, 0, 0, 8'(i));
    cyc(0, 0, 0, 1, 0, 8'h00);
    cyc(0, 0, 0, 1, 0, 8'h00);
    check("mid_pkt_dout", 32'(data_out), 32'h01);
    cyc(0, 1, 1, 1, 0, 8'h77);
    check("srst_empty", 32'(empty), 32'd1);
    check("srst_dout", 32'(data_out), 32'h00);
    check("srst_pkt_cnt", 32'(dut.pkt_cnt_q), 32'd0);
    cyc(0, 0, 1, 0, 1, 8'h06);
    cyc(0, 0, 1, 0, 0, 8'hA1);
    cyc(0, 0, 1, 0, 0, 8'hB2);
    cyc(0, 0, 0, 1, 0, 8'h00);
    check("new_hdr", 32'(data_out), 32'h06);
    cyc(0, 0, 0, 1, 0, 8'h00);
    check("new_payload", 32'(data_out), 32'hA1);
    cyc(0, 0, 0, 1, 0, 8'h00);
    check("new_parity", 32'(data_out), 32'hB2);
    cyc(0, 0, 0, 0, 0, 8'h00);
    check("new_idle", 32'(data_out), 32'h00);

    // Wrap-around: 3 passes of 12-in/12-out across the pointer lap bit.
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < 12; i++) cyc(0, 0, 1, 0, 0, 8'($urandom));
      check("wrap_notfull", 32'(full), 32'd0);
      for (int i = 0; i < 12; i++) cyc(0, 0, 0, 1, 0, 8'h00);
      check("wrap_empty", 32'(empty), 32'd1);
    end

    // Randomised traffic against the model, with occasional flushes.
    cyc(1, 0, 0, 0, 0, 8'h00);
    for (int i = 0; i < 3000; i++) begin
      cyc(1'b0, ($urandom_range(0, 99) == 0), ($urandom_range(0, 99) < 55),
          ($urandom_range(0, 99) < 50), ($urandom_range(0, 9) == 0), 8'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
